// File: rtl/conv_fetch_ctrl_pkg.sv
// Shared constants, FSM encoding and 3x3 tap-offset table for the convolution fetch controller.
package conv_fetch_ctrl_pkg;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int DATA_W = 20;

    localparam int         N_TAPS   = 9;
    localparam logic [3:0] LAST_TAP = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } tap_off_t;

    // Row-major window walk from (-1,-1) to (+1,+1).
    localparam tap_off_t TAP_OFS [N_TAPS] = '{
        '{-2'sd1, -2'sd1}, '{-2'sd1, 2'sd0}, '{-2'sd1, 2'sd1},
        '{ 2'sd0, -2'sd1}, '{ 2'sd0, 2'sd0}, '{ 2'sd0, 2'sd1},
        '{ 2'sd1, -2'sd1}, '{ 2'sd1, 2'sd0}, '{ 2'sd1, 2'sd1}
    };

endpackage

// File: rtl/conv_fetch_ctrl_addr_gen.sv
// Raster row/col/tap counters for the output pixel walk, plus per-tap bounds check and read address.
module conv_addr_gen #(
    parameter  int IMG_W  = 64,
    parameter  int IMG_H  = 64,
    localparam int ROW_W  = $clog2(IMG_H),
    localparam int COL_W  = $clog2(IMG_W),
    localparam int ADDR_W = ROW_W + COL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [3:0]        tap,
    output logic              in_range,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_last
);
    import conv_fetch_ctrl_pkg::*;

    tap_off_t                ofs;
    logic signed [ROW_W:0]   tgt_row;
    logic signed [COL_W:0]   tgt_col;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
            tap <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
            tap <= '0;
        end else if (advance) begin
            if (tap == LAST_TAP) begin
                tap <= '0;
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                tap <= tap + 4'd1;
            end
        end
    end

    assign ofs = TAP_OFS[tap];

    // One extra sign bit: -1 and IMG_H (or IMG_W) both land with the top bit set,
    // so a single bit flags either edge of the image.
    assign tgt_row = $signed({1'b0, row}) + $signed({{(ROW_W-1){ofs.dr[1]}}, ofs.dr});
    assign tgt_col = $signed({1'b0, col}) + $signed({{(COL_W-1){ofs.dc[1]}}, ofs.dc});

    assign in_range   = ~tgt_row[ROW_W] & ~tgt_col[COL_W];
    assign addr       = {tgt_row[ROW_W-1:0], tgt_col[COL_W-1:0]};
    assign frame_last = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1)) && (tap == LAST_TAP);

endmodule

// File: rtl/conv_fetch_ctrl.sv
// 3x3 window fetch controller: walks the image in raster order, reads in-range taps and streams
// them (zero for padding) through a 2-entry buffer under a valid/ready handshake.
module conv_fetch_ctrl #(
    parameter  int IMG_W  = conv_fetch_ctrl_pkg::IMG_W,
    parameter  int IMG_H  = conv_fetch_ctrl_pkg::IMG_H,
    parameter  int DATA_W = conv_fetch_ctrl_pkg::DATA_W,
    localparam int ROW_W  = $clog2(IMG_H),
    localparam int COL_W  = $clog2(IMG_W),
    localparam int ADDR_W = ROW_W + COL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic              ird,
    output logic [ADDR_W-1:0] iaddr,
    input  logic [DATA_W-1:0] idata,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [DATA_W-1:0] px_data,
    output logic [3:0]        px_tap,
    output logic              px_last,
    output logic [ROW_W-1:0]  px_row,
    output logic [COL_W-1:0]  px_col,
    output logic              done
);
    import conv_fetch_ctrl_pkg::*;

    state_t state, state_nxt;

    logic [ROW_W-1:0]  ag_row;
    logic [COL_W-1:0]  ag_col;
    logic [3:0]        ag_tap;
    logic              ag_in_range;
    logic [ADDR_W-1:0] ag_addr;
    logic              ag_frame_last;
    logic              ag_clear;
    logic              issue;

    // Read-latency stage: tap metadata waiting for idata.
    logic              s1_valid;
    logic              s1_in_range;
    logic [3:0]        s1_tap;
    logic [ROW_W-1:0]  s1_row;
    logic [COL_W-1:0]  s1_col;

    logic [DATA_W-1:0] buf_data [2];
    logic [3:0]        buf_tap  [2];
    logic [ROW_W-1:0]  buf_row  [2];
    logic [COL_W-1:0]  buf_col  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        buf_cnt;

    logic              push;
    logic              pop;
    logic [2:0]        occ_after;
    logic              has_credit;

    conv_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (ag_clear),
        .advance    (issue),
        .row        (ag_row),
        .col        (ag_col),
        .tap        (ag_tap),
        .in_range   (ag_in_range),
        .addr       (ag_addr),
        .frame_last (ag_frame_last)
    );

    assign push = s1_valid;
    assign pop  = (buf_cnt != 2'd0) && px_ready;

    // Occupancy once this cycle's push/pop settle; a tap issued now lands one cycle later,
    // so issuing is safe only if at most one entry is taken after this cycle.
    assign occ_after  = 3'(buf_cnt) + 3'(s1_valid) - 3'(pop);
    assign has_credit = (occ_after <= 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        ag_clear  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                ag_clear = 1'b1;
                if (ready) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy  = 1'b1;
                issue = has_credit;
                if (has_credit && ag_frame_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!s1_valid && occ_after == 3'd0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ird   = issue && ag_in_range;
    assign iaddr = ird ? ag_addr : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_tap      <= '0;
            s1_row      <= '0;
            s1_col      <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_in_range <= ag_in_range;
                s1_tap      <= ag_tap;
                s1_row      <= ag_row;
                s1_col      <= ag_col;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            buf_cnt <= occ_after[1:0];
        end
    end

    // NOTE: entry storage has no reset; the outputs below are gated by the reset-cleared count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= s1_in_range ? idata : '0;
            buf_tap[wr_ptr]  <= s1_tap;
            buf_row[wr_ptr]  <= s1_row;
            buf_col[wr_ptr]  <= s1_col;
        end
    end

    assign px_valid = (buf_cnt != 2'd0);
    assign px_data  = px_valid ? buf_data[rd_ptr] : '0;
    assign px_tap   = px_valid ? buf_tap[rd_ptr]  : '0;
    assign px_row   = px_valid ? buf_row[rd_ptr]  : '0;
    assign px_col   = px_valid ? buf_col[rd_ptr]  : '0;
    assign px_last  = px_valid && (buf_tap[rd_ptr] == LAST_TAP);

endmodule

// File: doc/conv_fetch_ctrl.md
CONV_FETCH_CTRL -- requirements
Module: conv_fetch_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning image width in pixels (power of two).
REQ-002 SHALL have parameter IMG_H, default 64, meaning image height in pixels (power of two).
REQ-003 SHALL have parameter DATA_W, default 20, meaning pixel width, signed 4.16 fixed point.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port ready, input, 1, image memory loaded; start request.
REQ-007 SHALL have port busy, output, 1, frame in progress.
REQ-008 SHALL have port ird, output, 1, image read strobe.
REQ-009 SHALL have port iaddr, output, log2(IMG_W*IMG_H) (12 at defaults), image read address, row*IMG_W+col.
REQ-010 SHALL have port idata, input, DATA_W, read data, valid in the cycle after ird/iaddr.
REQ-011 SHALL have port px_valid, output, 1, tap output valid.
REQ-012 SHALL have port px_ready, input, 1, downstream accepts tap.
REQ-013 SHALL have port px_data, output, DATA_W, tap pixel value (zero for padding).
REQ-014 SHALL have port px_tap, output, 4, tap index 0..8, row-major from (-1,-1) to (+1,+1).
REQ-015 SHALL have port px_last, output, 1, high with tap 8 (window complete).
REQ-016 SHALL have port px_row / px_col, output, 6 each, output-pixel coordinate of the tap.
REQ-017 SHALL have port done, output, 1, one-cycle frame-complete pulse.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE: busy=0; ready=1 sampled -> FETCH, busy=1 from the next cycle.
REQ-020 ready SHALL be ignored in every state except IDLE.
REQ-021 FETCH SHALL walk output pixels in raster order (row 0..IMG_H-1, col 0..IMG_W-1), 9 taps per pixel, tap order 0..8.
REQ-022 In-range tap: ird=1, iaddr=(row+dr)*IMG_W+(col+dc) for one cycle; data is registered onto px_data the cycle idata is valid, so px_valid rises 2 cycles after ird.
REQ-023 Out-of-range tap (row+dr or col+dc outside image): ird=0, px_data=0; it SHALL keep its position in tap order and latency.
REQ-024 Handshake: a tap transfers when px_valid&px_ready; px_data/tap/last/row/col SHALL be held stable while px_valid&!px_ready.
REQ-025 A 2-entry output buffer SHALL absorb the 1-cycle read latency; a new tap is issued only when a free entry exists counting in-flight reads, so no tap is lost or duplicated.
REQ-026 With px_ready held high, throughput SHALL be one tap per cycle.
REQ-027 After the last tap (row IMG_H-1, col IMG_W-1, tap 8) issues -> DRAIN; no further ird.
REQ-028 DRAIN -> DONE when the buffer is empty and no read is in flight; DONE asserts done=1 for one cycle, busy=0 in that same cycle, then -> IDLE.
REQ-029 Total taps per frame SHALL be exactly IMG_W*IMG_H*9 (36864 at defaults).
REQ-030 Address arithmetic SHALL use row/col widths +1 sign bit for bounds; iaddr never exceeds IMG_W*IMG_H-1.

Reset
REQ-031 reset SHALL force IDLE and busy=0, ird=0, iaddr=0, px_valid=0, px_data=0, px_tap=0, px_last=0, px_row=0, px_col=0, done=0, buffer empty.
REQ-032 reset mid-frame SHALL abort immediately; no done pulse; the next ready restarts from row 0, col 0, tap 0.

Structure
REQ-033 Shared package SHALL hold IMG_W, IMG_H, DATA_W, the state encoding and the tap-offset table (dr,dc per tap index).
REQ-034 Row/col/tap counters and bounds check SHALL be one sub-module, conv_addr_gen; buffer and FSM stay in conv_fetch_ctrl.

Verification
REQ-035 Reset, ready pulse, px_ready=1 -> first px_valid: tap 0, row 0, col 0, px_data=0, ird never high for it; tap 4 reads iaddr=0.
REQ-036 Pixel (1,1), memory value = address -> taps 0..8 = 0,1,2,64,65,66,128,129,130.
REQ-037 Corner pixel (63,63) -> taps 2,5,6,7,8 zero, no ird issued for them; tap 0 reads iaddr 4030.
REQ-038 Random px_ready toggling (50%) -> 36864 transfers, sequence identical to the stall-free run, outputs stable under stall.
REQ-039 Full frame, px_ready=1 -> done one cycle after final accepted tap, busy falls with done; ready during busy ignored.
REQ-040 reset asserted at tap 20000 -> all outputs zero next edge; new ready yields tap 0 at (0,0), full 36864-tap frame.
